// File: rtl/ls193_pulse_sequencer_if.sv
// Purpose: command and pin bundle between the pulse sequencer and its neighbours.
// Ports: cmd_* handshake from the CPU-side driver, up/down/load_n/clr/ld_data pins
//        to a 193-type counter, co_n/bo_n back from it, done/wrapped status.
interface ls193_pulse_sequencer_if #(
  parameter int NW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [3:0]    cmd_data;
  logic [NW-1:0] cmd_n;
  logic          up;
  logic          down;
  logic          load_n;
  logic          clr;
  logic [3:0]    ld_data;
  logic          co_n;
  logic          bo_n;
  logic          done;
  logic          wrapped;

  // Command driver and counter model side.
  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_n, co_n, bo_n,
    input  cmd_ready, up, down, load_n, clr, ld_data, done, wrapped
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_n, co_n, bo_n,
    output cmd_ready, up, down, load_n, clr, ld_data, done, wrapped
  );
endinterface

// File: rtl/ls193_pulse_sequencer.sv
// Purpose: turns CLEAR/LOAD/UP N/DOWN N commands into timed pin waveforms for a
//          4-bit 193-type up/down counter and flags carry/borrow seen while counting.
// Ports: clk, rst (async, active high); bus = slave side of ls193_pulse_sequencer_if.
module ls193_pulse_sequencer #(
  parameter int PW = 2,
  parameter int NW = 8
) (
  input  logic clk,
  input  logic rst,
  ls193_pulse_sequencer_if.slave bus
);

  localparam int PWW = (PW > 1) ? $clog2(PW) : 1;
  localparam logic [PWW-1:0] PH_LAST = PWW'(PW - 1);

  localparam logic [1:0] OP_CLEAR = 2'd0;
  localparam logic [1:0] OP_LOAD  = 2'd1;

  typedef enum logic [2:0] {
    IDLE,
    CLR_HI,
    LD_LO,
    CNT_LO,
    CNT_HI,
    FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [PWW-1:0] ph_q, ph_d;
  logic [NW-1:0] n_q, n_d;
  logic          dir_down_q, dir_down_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          up_q, up_d;
  logic          down_q, down_d;
  logic          load_n_q, load_n_d;
  logic          clr_q, clr_d;
  logic [3:0]    ld_data_q, ld_data_d;
  logic          done_q, done_d;
  logic          wrapped_q, wrapped_d;
  logic          accept;

  assign accept = bus.cmd_valid && cmd_ready_q;

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    n_d        = n_q;
    dir_down_d = dir_down_q;
    ld_data_d  = ld_data_q;
    wrapped_d  = wrapped_q;

    // Carry/borrow are only meaningful while our own pin is held low, so
    // sample them against the registered pin rather than the state.
    if ((!up_q && !bus.co_n) || (!down_q && !bus.bo_n)) begin
      wrapped_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          ph_d = '0;
          if (bus.cmd_op == OP_CLEAR) begin
            state_d = CLR_HI;
          end else if (bus.cmd_op == OP_LOAD) begin
            state_d   = LD_LO;
            ld_data_d = bus.cmd_data;
          end else begin
            dir_down_d = bus.cmd_op[0];
            wrapped_d  = 1'b0;
            n_d        = bus.cmd_n;
            state_d    = (bus.cmd_n == '0) ? FINISH : CNT_LO;
          end
        end
      end
      CLR_HI, LD_LO: begin
        if (ph_q == PH_LAST) begin
          ph_d    = '0;
          state_d = FINISH;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      CNT_LO: begin
        if (ph_q == PH_LAST) begin
          ph_d    = '0;
          n_d     = n_q - 1'b1;
          state_d = CNT_HI;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      CNT_HI: begin
        if (ph_q == PH_LAST) begin
          ph_d    = '0;
          state_d = (n_q == '0) ? FINISH : CNT_LO;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Pins follow the state one cycle later, so every output comes straight
    // from a flop; this gives the extra setup cycle before the first pin edge.
    up_d        = !(state_q == CNT_LO && !dir_down_q);
    down_d      = !(state_q == CNT_LO && dir_down_q);
    load_n_d    = (state_q != LD_LO);
    clr_d       = (state_q == CLR_HI);
    done_d      = (state_q == FINISH);
    cmd_ready_d = (state_q == FINISH) || (state_q == IDLE && !accept);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ph_q        <= '0;
      n_q         <= '0;
      dir_down_q  <= 1'b0;
      cmd_ready_q <= 1'b1;
      up_q        <= 1'b1;
      down_q      <= 1'b1;
      load_n_q    <= 1'b1;
      clr_q       <= 1'b0;
      ld_data_q   <= 4'h0;
      done_q      <= 1'b0;
      wrapped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      n_q         <= n_d;
      dir_down_q  <= dir_down_d;
      cmd_ready_q <= cmd_ready_d;
      up_q        <= up_d;
      down_q      <= down_d;
      load_n_q    <= load_n_d;
      clr_q       <= clr_d;
      ld_data_q   <= ld_data_d;
      done_q      <= done_d;
      wrapped_q   <= wrapped_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.up        = up_q;
  assign bus.down      = down_q;
  assign bus.load_n    = load_n_q;
  assign bus.clr       = clr_q;
  assign bus.ld_data   = ld_data_q;
  assign bus.done      = done_q;
  assign bus.wrapped   = wrapped_q;

endmodule

// File: tb/tb_ls193_pulse_sequencer.sv
// Purpose: directed, table-driven bench for ls193_pulse_sequencer with a 193 counter model.
// Ports: none; drives the master side of the interface, models co_n/bo_n from the counter.
module tb_ls193_pulse_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ls193_pulse_sequencer_if #(.NW(8)) bus ();

  ls193_pulse_sequencer #(.PW(2), .NW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural 193: async-style CLR/LOAD, counts on the rising edge of UP/DOWN.
  logic [3:0] q = 4'h0;
  logic up_p = 1'b1;
  logic down_p = 1'b1;
  int excl_bad = 0;

  always @(negedge clk) begin
    if (bus.clr) q <= 4'h0;
    else if (!bus.load_n) q <= bus.ld_data;
    else if (bus.up && !up_p) q <= q + 4'h1;
    else if (bus.down && !down_p) q <= q - 4'h1;
    up_p   <= bus.up;
    down_p <= bus.down;
    if ((int'(!bus.up) + int'(!bus.down) + int'(!bus.load_n) + int'(bus.clr)) > 1)
      excl_bad <= excl_bad + 1;
  end

  assign bus.co_n = !(!bus.up && q == 4'hF);
  assign bus.bo_n = !(!bus.down && q == 4'h0);

  localparam logic [1:0] OP_CLEAR = 2'd0;
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_UP    = 2'd2;
  localparam logic [1:0] OP_DOWN  = 2'd3;

  typedef struct {
    logic [1:0] op;
    logic [3:0] data;
    logic [7:0] n;
    int         lat;
    int         q;
    int         wr;
    int         ups;
    int         downs;
    int         loads;
    int         clrs;
    int         ld;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [3:0] data, input logic [7:0] n,
                              input int lat, input int qv, input int wr, input int ups,
                              input int downs, input int loads, input int clrs, input int ld);
    vec_t v;
    v.op = op; v.data = data; v.n = n; v.lat = lat; v.q = qv; v.wr = wr;
    v.ups = ups; v.downs = downs; v.loads = loads; v.clrs = clrs; v.ld = ld;
    return v;
  endfunction

  // Called at a negedge with the sequencer ready; leaves off at the negedge of the done cycle.
  task automatic run_cmd(input vec_t v, input int idx);
    int lat, ups, downs, loads, clrs;
    lat = 0; ups = 0; downs = 0; loads = 0; clrs = 0;
    chk("ready_before", idx, int'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = v.op;
    bus.cmd_data  = v.data;
    bus.cmd_n     = v.n;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_DOWN;
    bus.cmd_data  = 4'h7;
    bus.cmd_n     = 8'd9;
    chk("ready_drop", idx, int'(bus.cmd_ready), 0);
    do begin
      @(negedge clk);
      lat++;
      if (!bus.up) ups++;
      if (!bus.down) downs++;
      if (!bus.load_n) loads++;
      if (bus.clr) clrs++;
    end while (!bus.done && lat < 200);
    chk("latency", idx, lat, v.lat);
    chk("ready_at_done", idx, int'(bus.cmd_ready), 1);
    chk("counter", idx, int'(q), v.q);
    chk("wrapped", idx, int'(bus.wrapped), v.wr);
    chk("up_low_cycles", idx, ups, v.ups);
    chk("down_low_cycles", idx, downs, v.downs);
    chk("load_low_cycles", idx, loads, v.loads);
    chk("clr_high_cycles", idx, clrs, v.clrs);
    chk("ld_data", idx, int'(bus.ld_data), v.ld);
  endtask

  vec_t vecs[11];

  initial begin
    // op, data, n, latency, counter, wrapped, up/down/load/clr active cycles, ld_data
    vecs[0]  = mk(OP_LOAD,  4'hA, 8'd0,  4, 4'hA, 0, 0, 0, 2, 0, 4'hA);
    vecs[1]  = mk(OP_CLEAR, 4'h0, 8'd0,  4, 4'h0, 0, 0, 0, 0, 2, 4'hA);
    vecs[2]  = mk(OP_UP,    4'h0, 8'd3, 14, 4'h3, 0, 6, 0, 0, 0, 4'hA);
    vecs[3]  = mk(OP_LOAD,  4'hE, 8'd0,  4, 4'hE, 0, 0, 0, 2, 0, 4'hE);
    vecs[4]  = mk(OP_UP,    4'h0, 8'd3, 14, 4'h1, 1, 6, 0, 0, 0, 4'hE);
    vecs[5]  = mk(OP_CLEAR, 4'h0, 8'd0,  4, 4'h0, 1, 0, 0, 0, 2, 4'hE);
    vecs[6]  = mk(OP_DOWN,  4'h0, 8'd1,  6, 4'hF, 1, 0, 2, 0, 0, 4'hE);
    vecs[7]  = mk(OP_CLEAR, 4'h0, 8'd0,  4, 4'h0, 1, 0, 0, 0, 2, 4'hE);
    vecs[8]  = mk(OP_UP,    4'h3, 8'd0,  2, 4'h0, 0, 0, 0, 0, 0, 4'hE);
    vecs[9]  = mk(OP_DOWN,  4'h0, 8'd2, 10, 4'hE, 1, 0, 4, 0, 0, 4'hE);
    vecs[10] = mk(OP_LOAD,  4'h5, 8'd0,  4, 4'h5, 1, 0, 0, 2, 0, 4'h5);

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_CLEAR;
    bus.cmd_data  = 4'h0;
    bus.cmd_n     = 8'd0;

    repeat (3) @(negedge clk);
    chk("rst_ready", 0, int'(bus.cmd_ready), 1);
    chk("rst_up", 0, int'(bus.up), 1);
    chk("rst_down", 0, int'(bus.down), 1);
    chk("rst_load_n", 0, int'(bus.load_n), 1);
    chk("rst_clr", 0, int'(bus.clr), 0);
    chk("rst_ld_data", 0, int'(bus.ld_data), 0);
    chk("rst_done", 0, int'(bus.done), 0);
    chk("rst_wrapped", 0, int'(bus.wrapped), 0);
    rst = 1'b0;
    @(negedge clk);

    // Each command after the first is offered in the previous command's done cycle.
    for (int i = 0; i < 11; i++) run_cmd(vecs[i], i);

    // Reset during the second low phase of UP N=5.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_UP;
    bus.cmd_n     = 8'd5;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_up_low", 0, int'(bus.up), 0);
    chk("mid_ready_busy", 0, int'(bus.cmd_ready), 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_up", 0, int'(bus.up), 1);
    chk("mid_rst_ready", 0, int'(bus.cmd_ready), 1);
    chk("mid_rst_ld_data", 0, int'(bus.ld_data), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Recover a known count, then a back-to-back LOAD in the CLEAR's done cycle.
    run_cmd(mk(OP_CLEAR, 4'h0, 8'd0, 4, 4'h0, 0, 0, 0, 0, 2, 4'h0), 11);
    run_cmd(mk(OP_LOAD,  4'h3, 8'd0, 4, 4'h3, 0, 0, 0, 2, 0, 4'h3), 12);
    @(negedge clk);
    chk("done_one_cycle", 0, int'(bus.done), 0);

    chk("pin_exclusivity", 0, excl_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
